data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 16, word width in bits.
- ADDR_W, 16, byte-address width in bits.
- DEPTH, 256, number of words stored.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, single clock; all state changes on its rising edge except reset.
- rst_n, input, 1, reset; asynchronous, active-low.
- address, input, ADDR_W, byte address; word index = address[ADDR_W-1:1].
- data_write, input, DATA_W, write data.
- mem_write, input, 1, write enable.
- data_read, output, DATA_W, read data.
- mem_read, input, 1, read enable.

REQ-003 Non-reset port order SHALL be clk, address, data_write, mem_write, data_read, mem_read, with rst_n placed immediately after clk.

Function
REQ-004 Storage SHALL be DEPTH words of DATA_W bits, byte-addressed, 16-bit aligned: byte address 0 maps to word 0, byte address 2 maps to word 1.

REQ-005 Writes:
- Synchronous; on a rising clk edge with mem_write=1, mem[index] <= data_write.
- With mem_write=0, memory SHALL be unchanged regardless of address or data_write.

REQ-006 Reads:
- Combinational; data_read = mem[index] while mem_read=1.
- data_read = 0 while mem_read=0.
- Zero-latency response to address changes.

REQ-007 Simultaneous read and write to the same word:
- data_read SHALL show the old content until the write edge, then the new content.
- There SHALL be no write-through before the edge.

REQ-008 mem_read and mem_write SHALL be independent; both high is legal.

REQ-009 address[0] SHALL be ignored for indexing.

REQ-010 Out-of-range indices (index >= DEPTH) SHALL wrap modulo DEPTH, unless REQ-014 applies.

Reset
REQ-011 rst_n=0 SHALL asynchronously clear every memory word to 0; data_read SHALL follow REQ-006, so it reads 0.

REQ-012 While rst_n=0, writes SHALL be ignored.

REQ-013 Deassertion SHALL take effect at the next rising clk edge; reset asserted mid-write SHALL win over the write.

Configuration
REQ-014 Macro DATA_MEMORY_ACCESS_CHECK_EN:
- Defined:
  - Adds output port err (1 bit), placed last.
  - err is combinationally 1 when (mem_read or mem_write) is 1 and (address[0]=1 or index >= DEPTH); otherwise 0.
  - Flagged writes SHALL be suppressed.
  - Flagged reads SHALL return 0.
  - err SHALL be 0 during reset.
- Not defined:
  - No err port.
  - Behaviour per REQ-009 and REQ-010.

Verification
REQ-015 Reset then read: rst_n pulse low, mem_read=1, address=0x0002 -> data_read=0x0000.

REQ-016 Write then read:
- address=0x0000, data_write=0xEE44, mem_write=1 for one edge.
- Then mem_write=0, mem_read=1 -> data_read=0xEE44.

REQ-017 Write disabled:
- address=0x0002, data_write=0xFEE4, mem_write=0 across edges.
- Then read address 0x0002 -> 0x0000; address 0x0000 still reads 0xEE44.

REQ-018 Read gating: mem_read=0 with word 0 holding 0xEE44 -> data_read=0x0000; raise mem_read -> 0xEE44 in the same cycle.

REQ-019 Reset mid-write:
- rst_n low with mem_write=1, data_write=0x1234, address=0x0004 -> word 2 reads 0x0000 after reset.
- A following edge with rst_n=1 writes 0x1234.

REQ-020 Access check, with DATA_MEMORY_ACCESS_CHECK_EN:
- Write to address 0x0001 -> err=1, no write occurs.
- Address 2*DEPTH -> err=1.
- Without the macro, address 2*DEPTH aliases word 0.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressed, word-aligned data memory: synchronous write, combinational read.
// Optional DATA_MEMORY_ACCESS_CHECK_EN adds err and blocks misaligned/out-of-range accesses.
module data_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_write,
    input  logic              mem_write,
    output logic [DATA_W-1:0] data_read,
    input  logic              mem_read
`ifdef DATA_MEMORY_ACCESS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-2:0] full_idx;
    logic [ADDR_W-2:0] wrap_idx;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              bad;
    logic              wr_en;

    assign full_idx = address[ADDR_W-1:1];
    assign wrap_idx = full_idx % DEPTH_L;
    assign idx      = wrap_idx[IDX_W-1:0];
    assign in_range = full_idx < DEPTH_L;

`ifdef DATA_MEMORY_ACCESS_CHECK_EN
    assign bad = address[0] | ~in_range;
    assign err = rst_n & (mem_read | mem_write) & bad;
`else
    // Without checking, bit 0 and the range flag only feed this sink.
    logic unused_bits;
    assign unused_bits = address[0] ^ in_range;
    assign bad = 1'b0;
`endif

    assign wr_en = mem_write & ~bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= data_write;
        end
    end

    // Old contents stay visible until the write edge; no bypass path.
    always_comb begin
        data_read = '0;
        if (mem_read && !bad) begin
            data_read = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory.
// Optional macro DATA_MEMORY_ACCESS_CHECK_EN selects the err-port checks.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] data_write;
    logic        mem_write;
    logic [15:0] data_read;
    logic        mem_read;
`ifdef DATA_MEMORY_ACCESS_CHECK_EN
    logic        err;
`endif

    int n_checks;
    int n_fails;

    data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_write (data_write),
        .mem_write  (mem_write),
        .data_read  (data_read),
        .mem_read   (mem_read)
`ifdef DATA_MEMORY_ACCESS_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        re;
        logic        step;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] wd,
                         input logic we, input logic re);
        @(negedge clk);
        address    = a;
        data_write = wd;
        mem_write  = we;
        mem_read   = re;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        vecs[0]  = '{"wr_w0_gated",  16'h0000, 16'hEE44, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[1]  = '{"rd_w0",        16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hEE44};
        vecs[2]  = '{"wr_disabled",  16'h0002, 16'hFEE4, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[3]  = '{"rd_w1_zero",   16'h0002, 16'hFEE4, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[4]  = '{"rd_w0_kept",   16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hEE44};
        vecs[5]  = '{"rd_gated",     16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{"rd_ungated",   16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hEE44};
        vecs[7]  = '{"wr_rd_w3",     16'h0006, 16'hA5A5, 1'b1, 1'b1, 1'b1, 16'hA5A5};
        vecs[8]  = '{"wr_rd_w255",   16'h01FE, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h7777};
        vecs[9]  = '{"rd_w255",      16'h01FE, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h7777};
        vecs[10] = '{"rd_w3",        16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA5A5};

        address    = 16'h0000;
        data_write = 16'h0000;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        rst_n      = 1'b1;

        // Reset then read
        #2 rst_n = 1'b0;
        address  = 16'h0002;
        mem_read = 1'b1;
        #1 check("reset_rd_w1", data_read, 16'h0000);
        address = 16'h01FE;
        #1 check("reset_rd_w255", data_read, 16'h0000);
`ifdef DATA_MEMORY_ACCESS_CHECK_EN
        address = 16'h0001;
        #1 check("reset_err_low", {15'd0, err}, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
            if (vecs[i].step) @(posedge clk);
            #1 check(vecs[i].name, data_read, vecs[i].exp);
        end

        // Same-word read and write: old value until edge
        drive(16'h0006, 16'h1111, 1'b1, 1'b1);
        #1 check("rw_old_before_edge", data_read, 16'hA5A5);
        @(posedge clk);
        #1 check("rw_new_after_edge", data_read, 16'h1111);

        // Reset asserted mid-write
        drive(16'h0004, 16'h1234, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1 check("rst_midwrite_w2", data_read, 16'h0000);
        @(posedge clk);
        #1 check("rst_holds_w2", data_read, 16'h0000);
        address = 16'h0006;
        #1 check("rst_cleared_w3", data_read, 16'h0000);
        address = 16'h0004;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_no_write", data_read, 16'h0000);
        @(posedge clk);
        #1 check("post_rst_write_w2", data_read, 16'h1234);

`ifdef DATA_MEMORY_ACCESS_CHECK_EN
        drive(16'h0000, 16'h5A5A, 1'b1, 1'b1);
        @(posedge clk);
        #1 check("chk_w0_set", data_read, 16'h5A5A);
        drive(16'h0001, 16'hDEAD, 1'b1, 1'b0);
        #1 check("chk_err_odd_wr", {15'd0, err}, 16'h0001);
        @(posedge clk);
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        #1 check("chk_no_odd_write", data_read, 16'h5A5A);
        check("chk_err_clear", {15'd0, err}, 16'h0000);
        address = 16'h0200;
        #1 check("chk_err_range", {15'd0, err}, 16'h0001);
        check("chk_range_rd_zero", data_read, 16'h0000);
        mem_read = 1'b0;
        #1 check("chk_err_idle", {15'd0, err}, 16'h0000);
`else
        drive(16'h0200, 16'hBEEF, 1'b1, 1'b0);
        @(posedge clk);
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        #1 check("alias_2depth_w0", data_read, 16'hBEEF);
        address = 16'h0201;
        #1 check("alias_bit0_ignored", data_read, 16'hBEEF);
        address = 16'h0005;
        #1 check("bit0_ignored_w2", data_read, 16'h1234);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
